pwm_channel_bank: RTL and testbench



---
 rtl/pwm_bank_pkg.sv | 25 ++
 rtl/pwm_timebase.sv | 90 +++++++++
 rtl/pwm_channel_bank.sv | 134 +++++++++++++
 tb/tb_pwm_channel_bank.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_bank_pkg.sv
// +--------------------------------------------------------------------+
// | pwm_bank_pkg: register map and mode encoding for pwm_channel_bank   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package pwm_bank_pkg;

  localparam int unsigned ADDR_OUT_EN    = 'h00;
  localparam int unsigned ADDR_PWM_EN    = 'h01;
  localparam int unsigned ADDR_PERIOD    = 'h02;
  localparam int unsigned ADDR_PRESCALE  = 'h03;
  localparam int unsigned ADDR_CTRL      = 'h04;
  localparam int unsigned ADDR_DUTY_BASE = 'h10;
  // Enable bits beyond the data width live at this offset from their base
  localparam int unsigned ADDR_HI_OFFSET = 'h08;

  typedef enum logic {
    EDGE   = 1'b0,
    CENTER = 1'b1
  } pwm_mode_e;

endpackage

`default_nettype wire

// File: rtl/pwm_timebase.sv
// +--------------------------------------------------------------------+
// | pwm_timebase: prescaler, edge/center counter, boundary and tick     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module pwm_timebase
  import pwm_bank_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] prescale_i,
  input  logic [CNT_W-1:0] period_i,
  input  pwm_mode_e        mode_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             load_o,
  output logic             period_tick_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             down_q, down_d;
  logic             tick_q;
  logic             step;
  logic             boundary;

  always_comb begin
    step     = (presc_q >= prescale_i);
    presc_d  = step ? '0 : presc_q + CNT_ONE;
    cnt_d    = cnt_q;
    down_d   = down_q;
    boundary = 1'b0;
    if (step) begin
      if (mode_i == EDGE || period_i == '0) begin
        down_d = 1'b0;
        if (cnt_q >= period_i) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else if (!down_q) begin
        if (cnt_q >= period_i) begin
          // Turn around at the top; with PERIOD=1 the turn lands straight on 0
          cnt_d = period_i - CNT_ONE;
          if (cnt_d == '0) begin
            boundary = 1'b1;
          end else begin
            down_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        if (cnt_q <= CNT_ONE) begin
          cnt_d    = '0;
          down_d   = 1'b0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      down_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      down_q  <= down_d;
      tick_q  <= boundary;
    end
  end

  assign cnt_o         = cnt_q;
  assign load_o        = boundary;
  assign period_tick_o = tick_q;

endmodule

`default_nettype wire

// File: rtl/pwm_channel_bank.sv
// +--------------------------------------------------------------------+
// | pwm_channel_bank: register file, shadow/active copies, comparators |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module pwm_channel_bank
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  output logic              wr_err,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);

  localparam bit HAS_HI = (NUM_CH > CNT_W);

  logic [NUM_CH-1:0] out_en_q, out_en_d;
  logic [NUM_CH-1:0] pwm_en_q, pwm_en_d;
  logic [CNT_W-1:0]  prescale_q, prescale_d;
  logic [CNT_W-1:0]  period_sh_q, period_sh_d, period_act_q;
  pwm_mode_e         mode_sh_q, mode_sh_d, mode_act_q;
  logic              wr_err_q;

  logic [NUM_CH-1:0] hit_duty;
  logic              hit_out_lo, hit_out_hi, hit_pwm_lo, hit_pwm_hi;
  logic              hit_period, hit_presc, hit_ctrl, hit_any;
  logic [CNT_W-1:0]  cnt;
  logic              load;

  assign hit_out_lo = (wr_addr == ADDR_W'(ADDR_OUT_EN));
  assign hit_pwm_lo = (wr_addr == ADDR_W'(ADDR_PWM_EN));
  assign hit_out_hi = HAS_HI && (wr_addr == ADDR_W'(ADDR_OUT_EN + ADDR_HI_OFFSET));
  assign hit_pwm_hi = HAS_HI && (wr_addr == ADDR_W'(ADDR_PWM_EN + ADDR_HI_OFFSET));
  assign hit_period = (wr_addr == ADDR_W'(ADDR_PERIOD));
  assign hit_presc  = (wr_addr == ADDR_W'(ADDR_PRESCALE));
  assign hit_ctrl   = (wr_addr == ADDR_W'(ADDR_CTRL));
  assign hit_any    = hit_out_lo | hit_out_hi | hit_pwm_lo | hit_pwm_hi |
                      hit_period | hit_presc | hit_ctrl | (|hit_duty);

  always_comb begin
    prescale_d  = (wr_en && hit_presc)  ? wr_data : prescale_q;
    period_sh_d = (wr_en && hit_period) ? wr_data : period_sh_q;
    mode_sh_d   = (wr_en && hit_ctrl)   ? pwm_mode_e'(wr_data[0]) : mode_sh_q;
  end

  // Enable bits at or above the data width come from the high-offset register
  for (genvar i = 0; i < NUM_CH; i++) begin : g_en_bit
    if (i < CNT_W) begin : g_lo
      assign out_en_d[i] = (wr_en && hit_out_lo) ? wr_data[i] : out_en_q[i];
      assign pwm_en_d[i] = (wr_en && hit_pwm_lo) ? wr_data[i] : pwm_en_q[i];
    end else begin : g_hi
      assign out_en_d[i] = (wr_en && hit_out_hi) ? wr_data[i-CNT_W] : out_en_q[i];
      assign pwm_en_d[i] = (wr_en && hit_pwm_hi) ? wr_data[i-CNT_W] : pwm_en_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en_q     <= '0;
      pwm_en_q     <= '0;
      prescale_q   <= '0;
      period_sh_q  <= '1;
      period_act_q <= '1;
      mode_sh_q    <= EDGE;
      mode_act_q   <= EDGE;
      wr_err_q     <= 1'b0;
    end else begin
      out_en_q    <= out_en_d;
      pwm_en_q    <= pwm_en_d;
      prescale_q  <= prescale_d;
      period_sh_q <= period_sh_d;
      mode_sh_q   <= mode_sh_d;
      wr_err_q    <= wr_en & ~hit_any;
      // Old shadow value is what gets loaded if a write coincides with load
      if (load) begin
        period_act_q <= period_sh_q;
        mode_act_q   <= mode_sh_q;
      end
    end
  end

  pwm_timebase #(
    .CNT_W (CNT_W)
  ) u_timebase (
    .clk           (clk),
    .rst_n         (rst_n),
    .prescale_i    (prescale_q),
    .period_i      (period_act_q),
    .mode_i        (mode_act_q),
    .cnt_o         (cnt),
    .load_o        (load),
    .period_tick_o (period_tick)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] duty_sh_q;
    logic [CNT_W-1:0] duty_act_q;
    logic             pwm_q;

    assign hit_duty[i] = (wr_addr == ADDR_W'(ADDR_DUTY_BASE + i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_sh_q  <= '0;
        duty_act_q <= '0;
        pwm_q      <= 1'b0;
      end else begin
        if (wr_en && hit_duty[i]) begin
          duty_sh_q <= wr_data;
        end
        if (load) begin
          duty_act_q <= duty_sh_q;
        end
        pwm_q <= out_en_q[i] & (~pwm_en_q[i] | (cnt < duty_act_q));
      end
    end

    assign pwm_out[i] = pwm_q;
  end

  assign wr_err = wr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_channel_bank.sv
// +--------------------------------------------------------------------+
// | tb_pwm_channel_bank: directed self-checking bench for the PWM bank  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_pwm_channel_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_err;
  logic [7:0] pwm_out;
  logic       period_tick;

  int n_tests = 0;
  int n_fail  = 0;

  int          cyc, hi;
  logic [63:0] pat;

  pwm_channel_bank #(
    .NUM_CH (8),
    .CNT_W  (8),
    .ADDR_W (7)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_err      (wr_err),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the following negedge
  task automatic write_reg(input logic [6:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_tick(input int budget);
    int n = 0;
    @(negedge clk);
    while (!period_tick && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!period_tick) check("tick_timeout", 64'd0, 64'd1);
  endtask

  // Starts at a negedge where period_tick is high; samples ch0 each negedge
  // until the next tick. Optionally issues one write at sample index wr_idx.
  task automatic measure(input int wr_idx, input logic [6:0] a, input logic [7:0] d,
                         output int cycles, output int highs, output logic [63:0] p);
    cycles = 0;
    highs  = 0;
    p      = '0;
    for (int k = 0; k < 200; k++) begin
      if (k > 0 && period_tick) break;
      if (pwm_out[0]) begin
        highs++;
        if (k < 64) p[k] = 1'b1;
      end
      cycles++;
      if (k == wr_idx) begin
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
      end
      @(negedge clk);
      wr_en = 1'b0;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    #3;
    check("rst_pwm", 64'(pwm_out), 64'h0);
    check("rst_tick", 64'(period_tick), 64'h0);
    check("rst_err", 64'(wr_err), 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Edge mode, PERIOD=9, DUTY0=3
    write_reg(7'h02, 8'd9);
    write_reg(7'h10, 8'd3);
    write_reg(7'h00, 8'h01);
    write_reg(7'h01, 8'h01);
    check("wr_err_valid", 64'(wr_err), 64'h0);
    wait_tick(300);
    measure(-1, 7'h0, 8'h0, cyc, hi, pat);
    check("edge_cycles", 64'(cyc), 64'd10);
    measure(-1, 7'h0, 8'h0, cyc, hi, pat);
    check("edge_highs", 64'(hi), 64'd3);
    check("edge_pattern", pat, 64'h00E);
    check("other_ch_off", 64'(pwm_out[7:1]), 64'h0);

    // Prescaler 3 stretches the period to 40 clocks
    write_reg(7'h03, 8'd3);
    wait_tick(100);
    measure(-1, 7'h0, 8'h0, cyc, hi, pat);
    check("presc_cycles", 64'(cyc), 64'd40);
    check("presc_highs", 64'(hi), 64'd12);
    write_reg(7'h03, 8'd0);
    wait_tick(100);

    // Duty write mid-period applies from the next period only
    measure(0, 7'h10, 8'd7, cyc, hi, pat);
    check("duty_old_kept", 64'(hi), 64'd3);
    measure(-1, 7'h0, 8'h0, cyc, hi, pat);
    check("duty7_pattern", pat, 64'h0FE);

    // Write on the boundary cycle is deferred one more period
    measure(9, 7'h10, 8'd0, cyc, hi, pat);
    check("bnd_cur_highs", 64'(hi), 64'd7);
    measure(-1, 7'h0, 8'h0, cyc, hi, pat);
    check("bnd_next_highs", 64'(hi), 64'd7);
    measure(-1, 7'h0, 8'h0, cyc, hi, pat);
    check("duty0_const_low", 64'(hi), 64'd0);

    // Duty above PERIOD is constantly high
    measure(0, 7'h10, 8'hFF, cyc, hi, pat);
    measure(-1, 7'h0, 8'h0, cyc, hi, pat);
    measure(-1, 7'h0, 8'h0, cyc, hi, pat);
    check("dutyFF_pattern", pat, 64'h3FF);

    // Center mode, PERIOD=4, DUTY0=2
    write_reg(7'h02, 8'd4);
    write_reg(7'h10, 8'd2);
    write_reg(7'h04, 8'h01);
    wait_tick(100);
    measure(-1, 7'h0, 8'h0, cyc, hi, pat);
    check("center_cycles", 64'(cyc), 64'd8);
    measure(-1, 7'h0, 8'h0, cyc, hi, pat);
    check("center_highs", 64'(hi), 64'd3);
    check("center_pattern", pat, 64'h07);

    // PWM_EN=0 forces a static high, two cycles after the write
    repeat (3) @(negedge clk);
    write_reg(7'h01, 8'h00);
    check("pwmen_lat1", 64'(pwm_out[0]), 64'h0);
    @(negedge clk);
    check("pwmen_lat2", 64'(pwm_out[0]), 64'h1);
    wait_tick(100);
    measure(-1, 7'h0, 8'h0, cyc, hi, pat);
    check("pwmen_static", pat, 64'hFF);

    // Unmapped writes pulse wr_err once and change nothing
    write_reg(7'h3F, 8'hAA);
    check("err_pulse", 64'(wr_err), 64'h1);
    @(negedge clk);
    check("err_once", 64'(wr_err), 64'h0);
    write_reg(7'h18, 8'h00);
    check("err_duty8", 64'(wr_err), 64'h1);
    wait_tick(100);
    measure(-1, 7'h0, 8'h0, cyc, hi, pat);
    check("err_no_change", 64'(cyc), 64'd8);
    check("err_out_static", 64'(hi), 64'd8);

    // Asynchronous reset mid-run
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pwm", 64'(pwm_out), 64'h0);
    check("arst_tick", 64'(period_tick), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_pwm", 64'(pwm_out), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
